// File: rtl/cdb_pkg.sv
// cdb_pkg -- shared types and constants for the multi-port common data bus.
//   RegFile_t     : destination register tag carried with each result
//   ExpCode_t     : exception cause carried with each result
//   CdbPrior_t    : aging counter type at the default counter width
//   CDB_INIT_PRIOR: counter reload value at the default width
//   CDB_IDLE_*    : values driven on a writeback port that carries nothing
package cdb_pkg;

  localparam int CDB_PW   = 3;
  localparam int CDB_RF_W = 5;

  typedef logic [CDB_RF_W-1:0] RegFile_t;

  typedef enum logic [3:0] {
    EXP_I_MISS_ALIGN = 4'd0,
    EXP_I_ACC_FAULT  = 4'd1,
    EXP_ILLEGAL_INST = 4'd2,
    EXP_BREAKPOINT   = 4'd3,
    EXP_L_MISS_ALIGN = 4'd4,
    EXP_L_ACC_FAULT  = 4'd5,
    EXP_S_MISS_ALIGN = 4'd6,
    EXP_S_ACC_FAULT  = 4'd7,
    EXP_ECALL        = 4'd8
  } ExpCode_t;

  typedef logic [CDB_PW-1:0] CdbPrior_t;

  localparam CdbPrior_t CDB_INIT_PRIOR = '1;

  localparam logic     CDB_IDLE_E        = 1'b1;
  localparam RegFile_t CDB_IDLE_RD       = '0;
  localparam logic     CDB_IDLE_EXP      = 1'b1;
  localparam ExpCode_t CDB_IDLE_EXP_CODE = EXP_I_MISS_ALIGN;

  // Width of a unit index; kept at least 1 so a single-unit build still works.
  function automatic int cdb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_pick.sv
// cdb_pick -- selects the smallest key among UNITS candidates.
//   keys  : per-unit key {req_, counter, index}; MSB set means "not requesting"
//   excl  : units already taken by an earlier port in the chain
//   valid : a requesting, non-excluded unit was found
//   idx   : index of the winner (0 when !valid)
//   sel   : one-hot of the winner (all zero when !valid)
module cdb_pick #(
  parameter int UNITS = 6,
  parameter int KW    = 7,
  parameter int UW    = 3
) (
  input  logic [UNITS-1:0][KW-1:0] keys,
  input  logic [UNITS-1:0]         excl,
  output logic                     valid,
  output logic [UW-1:0]            idx,
  output logic [UNITS-1:0]         sel
);

  logic [KW-1:0] best;

  // NOTE: combinational logic uses blocking assignments, and every output gets
  // a default before the loop so no path leaves a value held (no latch).
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    best  = '1;
    for (int u = 0; u < UNITS; u++) begin
      if (!excl[u] && !keys[u][KW-1] && (!valid || keys[u] < best)) begin
        valid = 1'b1;
        best  = keys[u];
        idx   = UW'(u);
      end
    end
    sel = '0;
    for (int u = 0; u < UNITS; u++) begin
      sel[u] = valid && (idx == UW'(u));
    end
  end

endmodule

// File: rtl/cdb_mp.sv
// cdb_mp -- multi-port common data bus arbiter with aging priority.
// Up to PORTS of UNITS requesters win writeback each cycle; a requester that
// keeps losing has its counter aged down so its key eventually wins.
// Build option: CDB_OUT_REG_EN registers wb_* (1-cycle latency); without it
// wb_* are driven combinationally in the grant cycle.
//   clk, reset_ (sync, active-low), flush_ (active-low)
//   req_/ack_          : per-unit active-low request / grant
//   in_rd/in_data/in_exp_/in_exp_code : per-unit payload
//   pre_wb_e_/pre_wb_rd: per-port early wakeup, grant cycle
//   wb_e_/wb_rd/wb_data/wb_exp_/wb_exp_code : per-port broadcast
module cdb_mp
  import cdb_pkg::*;
#(
  parameter int UNITS      = 6,
  parameter int PORTS      = 2,
  parameter int DATA       = 64,
  parameter int PW         = CDB_PW,
  parameter int INIT_PRIOR = (1 << PW) - 1
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 flush_,
  input  logic [UNITS-1:0]     req_,
  output logic [UNITS-1:0]     ack_,
  input  RegFile_t             in_rd       [UNITS],
  input  logic [DATA-1:0]      in_data     [UNITS],
  input  logic [UNITS-1:0]     in_exp_,
  input  ExpCode_t             in_exp_code [UNITS],
  output logic [PORTS-1:0]     pre_wb_e_,
  output RegFile_t             pre_wb_rd   [PORTS],
  output logic [PORTS-1:0]     wb_e_,
  output RegFile_t             wb_rd       [PORTS],
  output logic [DATA-1:0]      wb_data     [PORTS],
  output logic [PORTS-1:0]     wb_exp_,
  output ExpCode_t             wb_exp_code [PORTS]
);

  localparam int UW = cdb_idx_w(UNITS);
  localparam int KW = 1 + PW + UW;
  localparam logic [PW-1:0] RELOAD = PW'(INIT_PRIOR);

  logic [PW-1:0]           cnt        [UNITS];
  logic [UNITS-1:0][KW-1:0] keys;
  logic [UNITS-1:0]        excl       [PORTS+1];
  logic [PORTS-1:0]        pick_valid;
  logic [UW-1:0]           pick_idx   [PORTS];
  logic [UNITS-1:0]        pick_sel   [PORTS];
  logic                    enable;
  logic [PORTS-1:0]        grant_valid;
  logic [UNITS-1:0]        granted;

  // Port-side payload of the current grant; either driven out directly or
  // captured, depending on the build option.
  logic [PORTS-1:0]        nxt_e_;
  RegFile_t                nxt_rd     [PORTS];
  logic [DATA-1:0]         nxt_data   [PORTS];
  logic [PORTS-1:0]        nxt_exp_;
  ExpCode_t                nxt_code   [PORTS];

  // The unit index in the low bits makes every key unique, so ties on the
  // counter resolve to the lowest index with a plain magnitude compare.
  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      keys[u] = {req_[u], cnt[u], UW'(u)};
    end
  end

  // Each picker excludes every unit already won by a lower-numbered port, so
  // port p receives the (p+1)-th smallest key and no unit gets two ports.
  assign excl[0] = '0;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    cdb_pick #(
      .UNITS (UNITS),
      .KW    (KW),
      .UW    (UW)
    ) u_pick (
      .keys  (keys),
      .excl  (excl[p]),
      .valid (pick_valid[p]),
      .idx   (pick_idx[p]),
      .sel   (pick_sel[p])
    );
    assign excl[p+1] = excl[p] | pick_sel[p];
  end

  // Reset and flush both suppress every grant in the current cycle.
  assign enable      = reset_ & flush_;
  assign grant_valid = pick_valid & {PORTS{enable}};
  assign granted     = excl[PORTS] & {UNITS{enable}};
  assign ack_        = ~granted;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      nxt_e_[p]   = CDB_IDLE_E;
      nxt_rd[p]   = CDB_IDLE_RD;
      nxt_data[p] = '0;
      nxt_exp_[p] = CDB_IDLE_EXP;
      nxt_code[p] = CDB_IDLE_EXP_CODE;
      if (grant_valid[p]) begin
        nxt_e_[p]   = 1'b0;
        nxt_rd[p]   = in_rd[pick_idx[p]];
        nxt_data[p] = in_data[pick_idx[p]];
        nxt_exp_[p] = in_exp_[pick_idx[p]];
        nxt_code[p] = in_exp_code[pick_idx[p]];
      end
    end
  end

  assign pre_wb_e_ = nxt_e_;
  assign pre_wb_rd = nxt_rd;

  // Aging: a requester that loses counts down (saturating); winning, idling,
  // flush or reset restores the full count.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    for (int u = 0; u < UNITS; u++) begin
      if (!reset_ || !flush_ || req_[u] || granted[u]) begin
        cnt[u] <= RELOAD;
      end else if (cnt[u] != '0) begin
        cnt[u] <= cnt[u] - 1'b1;
      end
    end
  end

`ifdef CDB_OUT_REG_EN
  // Registered broadcast; reset wins over any grant captured on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int p = 0; p < PORTS; p++) begin
        wb_e_[p]       <= CDB_IDLE_E;
        wb_rd[p]       <= CDB_IDLE_RD;
        wb_data[p]     <= '0;
        wb_exp_[p]     <= CDB_IDLE_EXP;
        wb_exp_code[p] <= CDB_IDLE_EXP_CODE;
      end
    end else begin
      wb_e_       <= nxt_e_;
      wb_rd       <= nxt_rd;
      wb_data     <= nxt_data;
      wb_exp_     <= nxt_exp_;
      wb_exp_code <= nxt_code;
    end
  end
`else
  // Zero-latency broadcast; flush and reset already idle the grant itself.
  assign wb_e_       = nxt_e_;
  assign wb_rd       = nxt_rd;
  assign wb_data     = nxt_data;
  assign wb_exp_     = nxt_exp_;
  assign wb_exp_code = nxt_code;
`endif

endmodule

// File: tb/tb_cdb_mp.sv
// tb_cdb_mp -- self-checking bench for cdb_mp (UNITS=6, PORTS=2, DATA=64).
// A sorted-key reference model predicts grants; predicted broadcasts go into
// a scoreboard queue and are compared when the DUT's broadcast is due.
module tb_cdb_mp;
  import cdb_pkg::*;

  localparam int UNITS = 6;
  localparam int PORTS = 2;
  localparam int DATA  = 64;
  localparam int PW    = 3;
  localparam int INIT  = 7;
`ifdef CDB_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                 clk;
  logic                 reset_;
  logic                 flush_;
  logic [UNITS-1:0]     req_;
  logic [UNITS-1:0]     ack_;
  RegFile_t             in_rd       [UNITS];
  logic [DATA-1:0]      in_data     [UNITS];
  logic [UNITS-1:0]     in_exp_;
  ExpCode_t             in_exp_code [UNITS];
  logic [PORTS-1:0]     pre_wb_e_;
  RegFile_t             pre_wb_rd   [PORTS];
  logic [PORTS-1:0]     wb_e_;
  RegFile_t             wb_rd       [PORTS];
  logic [DATA-1:0]      wb_data     [PORTS];
  logic [PORTS-1:0]     wb_exp_;
  ExpCode_t             wb_exp_code [PORTS];

  cdb_mp #(
    .UNITS (UNITS),
    .PORTS (PORTS),
    .DATA  (DATA),
    .PW    (PW)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .flush_      (flush_),
    .req_        (req_),
    .ack_        (ack_),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .in_exp_     (in_exp_),
    .in_exp_code (in_exp_code),
    .pre_wb_e_   (pre_wb_e_),
    .pre_wb_rd   (pre_wb_rd),
    .wb_e_       (wb_e_),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_exp_     (wb_exp_),
    .wb_exp_code (wb_exp_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            e_;
    RegFile_t        rd;
    logic [DATA-1:0] data;
    logic            exp_;
    ExpCode_t        code;
  } wb_exp_t;

  wb_exp_t sb [$];
  int      checks   = 0;
  int      failures = 0;
  int      cnt_m      [UNITS];
  int      grant_m    [PORTS];
  int      last_grant [UNITS];
  int      cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference grant: sort requesters by (counter, index) and hand out ports
  // in ascending order.
  function automatic void model_pick();
    int keys [$];
    for (int p = 0; p < PORTS; p++) grant_m[p] = -1;
    if (reset_ !== 1'b1 || flush_ !== 1'b1) return;
    for (int u = 0; u < UNITS; u++) begin
      if (req_[u] === 1'b0) keys.push_back(cnt_m[u] * UNITS + u);
    end
    keys.sort();
    for (int p = 0; p < PORTS; p++) begin
      if (p < keys.size()) grant_m[p] = keys[p] % UNITS;
    end
  endfunction

  // Sample the cycle's outputs at the falling edge and score them.
  task automatic sample(input string tag);
    logic [UNITS-1:0] exp_ack;
    wb_exp_t          e;
    wb_exp_t          got;
    @(negedge clk);
    model_pick();
    exp_ack = {UNITS{1'b1}};
    for (int p = 0; p < PORTS; p++) begin
      if (grant_m[p] >= 0) exp_ack[grant_m[p]] = 1'b0;
    end
    check($sformatf("%s ack_", tag), ack_, exp_ack);
    check($sformatf("%s one port per unit", tag), $countones(~ack_), PORTS - $countones(pre_wb_e_));
    for (int u = 0; u < UNITS; u++) begin
      if (ack_[u] === 1'b0) last_grant[u] = cyc;
    end
    for (int p = 0; p < PORTS; p++) begin
      e.e_ = 1'b1; e.rd = '0; e.data = '0; e.exp_ = 1'b1; e.code = EXP_I_MISS_ALIGN;
      if (grant_m[p] >= 0) begin
        e.e_   = 1'b0;
        e.rd   = in_rd[grant_m[p]];
        e.data = in_data[grant_m[p]];
        e.exp_ = in_exp_[grant_m[p]];
        e.code = in_exp_code[grant_m[p]];
      end
      check($sformatf("%s pre_wb_e_[%0d]", tag, p), pre_wb_e_[p], e.e_);
      check($sformatf("%s pre_wb_rd[%0d]", tag, p), pre_wb_rd[p], e.rd);
      sb.push_back(e);
    end
    while (sb.size() > LAT * PORTS) begin
      for (int p = 0; p < PORTS; p++) begin
        got = sb.pop_front();
        check($sformatf("%s wb_e_[%0d]", tag, p), wb_e_[p], got.e_);
        check($sformatf("%s wb_rd[%0d]", tag, p), wb_rd[p], got.rd);
        check($sformatf("%s wb_data[%0d]", tag, p), wb_data[p], got.data);
        check($sformatf("%s wb_exp_[%0d]", tag, p), wb_exp_[p], got.exp_);
        check($sformatf("%s wb_exp_code[%0d]", tag, p), wb_exp_code[p], got.code);
      end
    end
  endtask

  // Age the model counters, step the clock, compare the DUT counters.
  task automatic advance(input string tag);
    bit g;
    for (int u = 0; u < UNITS; u++) begin
      g = 1'b0;
      for (int p = 0; p < PORTS; p++) if (grant_m[p] == u) g = 1'b1;
      if (reset_ !== 1'b1 || flush_ !== 1'b1 || req_[u] !== 1'b0 || g) cnt_m[u] = INIT;
      else if (cnt_m[u] > 0) cnt_m[u] = cnt_m[u] - 1;
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < UNITS; u++) begin
      check($sformatf("%s cnt[%0d]", tag, u), dut.cnt[u], cnt_m[u]);
    end
    cyc++;
  endtask

  task automatic randomize_payload();
    for (int u = 0; u < UNITS; u++) begin
      in_rd[u]       = RegFile_t'($urandom_range(0, 31));
      in_data[u]     = {$urandom(), $urandom()};
      in_exp_[u]     = 1'($urandom_range(0, 1));
      in_exp_code[u] = ExpCode_t'($urandom_range(0, 8));
    end
  endtask

  initial begin
    reset_  = 1'b0;
    flush_  = 1'b1;
    req_    = {UNITS{1'b1}};
    in_exp_ = {UNITS{1'b1}};
    for (int u = 0; u < UNITS; u++) begin
      in_rd[u]       = '0;
      in_data[u]     = '0;
      in_exp_code[u] = EXP_I_MISS_ALIGN;
      cnt_m[u]       = INIT;
      last_grant[u]  = -10;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset holds grants off even with every unit requesting.
    req_ = {UNITS{1'b0}};
    sample("reset");
    check("reset ack_ all idle", ack_, {UNITS{1'b1}});
    check("reset pre_wb_e_ idle", pre_wb_e_, {PORTS{1'b1}});
    advance("reset");
    check("reset wb_e_ idle", wb_e_, {PORTS{1'b1}});
    check("reset wb_exp_ idle", wb_exp_, {PORTS{1'b1}});
    check("reset cnt[0]", dut.cnt[0], 7);

    reset_ = 1'b1;
    req_   = {UNITS{1'b1}};
    sample("idle");
    advance("idle");

    // Lone requester lands on port 0.
    req_           = 6'b110111;
    in_data[3]     = 64'hDEAD;
    in_rd[3]       = 5'd5;
    in_exp_code[3] = EXP_ECALL;
    sample("u3");
    check("u3 ack_[3]", ack_[3], 1'b0);
    check("u3 pre_wb_rd[0]", pre_wb_rd[0], 5);
    check("u3 pre_wb_e_", pre_wb_e_, 2'b10);
    advance("u3");
    req_ = {UNITS{1'b1}};
    sample("u3 after");
    advance("u3 after");

    // Three requesters, then aging lets unit 2 win port 0.
    for (int u = 0; u < UNITS; u++) in_rd[u] = RegFile_t'(8 + u);
    req_ = 6'b111000;
    sample("age1");
    check("age1 ack_", ack_, 6'b111100);
    check("age1 pre_wb_rd[0]", pre_wb_rd[0], 8);
    check("age1 pre_wb_rd[1]", pre_wb_rd[1], 9);
    advance("age1");
    check("age1 cnt[2] aged", dut.cnt[2], 6);
    sample("age2");
    check("age2 ack_", ack_, 6'b111010);
    check("age2 pre_wb_rd[0]", pre_wb_rd[0], 10);
    check("age2 pre_wb_rd[1]", pre_wb_rd[1], 8);
    advance("age2");

    // All units requesting: everyone served within any 3-cycle window.
    req_ = {UNITS{1'b0}};
    for (int i = 0; i < 30; i++) begin
      randomize_payload();
      sample("fair");
      advance("fair");
      if (i >= 2) begin
        for (int u = 0; u < UNITS; u++) begin
          check($sformatf("fair window unit %0d", u), last_grant[u] >= cyc - 3, 1'b1);
        end
      end
    end

    // Flush with four requesters drops everything, including exceptions.
    req_    = 6'b110000;
    in_exp_ = 6'b000000;
    flush_  = 1'b0;
    sample("flush");
    check("flush ack_", ack_, {UNITS{1'b1}});
    check("flush pre_wb_e_", pre_wb_e_, {PORTS{1'b1}});
    advance("flush");
    for (int u = 0; u < UNITS; u++) check($sformatf("flush reload cnt[%0d]", u), dut.cnt[u], 7);
    flush_  = 1'b1;
    req_    = {UNITS{1'b1}};
    in_exp_ = {UNITS{1'b1}};
    sample("post flush");
    check("post flush wb_e_", wb_e_, {PORTS{1'b1}});
    check("post flush wb_exp_", wb_exp_, {PORTS{1'b1}});
    advance("post flush");

    // Exception carried by unit 4.
    req_           = 6'b101111;
    in_exp_[4]     = 1'b0;
    in_exp_code[4] = EXP_I_MISS_ALIGN;
    in_data[4]     = 64'h1234_5678_9ABC_DEF0;
    sample("exp u4");
    check("exp u4 pre_wb_e_[0]", pre_wb_e_[0], 1'b0);
`ifndef CDB_OUT_REG_EN
    check("exp u4 wb_e_[0] same cycle", wb_e_[0], 1'b0);
    check("exp u4 wb_exp_[0] same cycle", wb_exp_[0], 1'b0);
`endif
    advance("exp u4");

    // Mixed random traffic with occasional flushes.
    for (int i = 0; i < 40; i++) begin
      randomize_payload();
      req_   = UNITS'($urandom_range(0, 63));
      flush_ = ($urandom_range(0, 5) != 0);
      sample("rand");
      advance("rand");
    end
    flush_ = 1'b1;

    // Grant in flight when reset arrives mid-operation is discarded.
    req_ = 6'b111100;
    sample("pre reset");
    advance("pre reset");
    reset_ = 1'b0;
    req_   = 6'b000011;
    sample("mid reset");
    check("mid reset ack_", ack_, {UNITS{1'b1}});
    advance("mid reset");
    check("mid reset wb_e_", wb_e_, {PORTS{1'b1}});
    reset_ = 1'b1;
    req_   = {UNITS{1'b1}};
    sample("drain");
    advance("drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
